// File: rtl/bus_slave_port.sv
// Serial bus slave port: deserialises RW/address/data frames, drives a local
// memory port, and serialises read data back. Define SPLIT_EN to enable split reads.
`timescale 1ns/1ps

module bus_slave_port #(
  parameter int ADDR_W       = 12,
  parameter int SPLIT_THRESH = 4
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              SEL,
  input  logic              BUS_VALID,
  input  logic              BUS_DATA,
  output logic              SLV_VALID,
  output logic              SLV_DATA,
  output logic              SLV_ACK,
  output logic              SLV_SPLIT,
  output logic [ADDR_W-1:0] S_ADDR,
  output logic [7:0]        S_DOUT,
  output logic              S_WEN,
  output logic              S_REN,
  input  logic [7:0]        S_DIN,
  input  logic              S_DVALID
);

  // One counter serves address bits, data bits, TX bits and the split wait.
  localparam int CNT_AB  = (ADDR_W > 8) ? ADDR_W : 8;
  localparam int CNT_MAX = (CNT_AB > SPLIT_THRESH) ? CNT_AB : SPLIT_THRESH;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
`ifdef SPLIT_EN
  localparam logic [CNT_W-1:0] SPLIT_LAST = CNT_W'(SPLIT_THRESH - 1);
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    WDATA  = 3'd2,
    MEM_WR = 3'd3,
    MEM_RD = 3'd4,
`ifdef SPLIT_EN
    SPLIT  = 3'd5,
`endif
    TX     = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_next_cnt;
  logic [7:0]        r_shift;
  logic [7:0]        w_next_shift;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_dout;
  logic              r_wen;
  logic              r_ren;
  logic              r_ack;
  logic              r_slv_valid;
  logic              r_slv_data;
  logic              w_bit;
`ifdef SPLIT_EN
  logic              r_got;
  logic              w_next_got;
  logic              r_split;
`endif

  assign w_bit = SEL & BUS_VALID;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    w_next       = r_state;
    w_next_cnt   = r_cnt;
    w_next_shift = r_shift;
`ifdef SPLIT_EN
    w_next_got   = r_got;
`endif
    case (r_state)
      IDLE: begin
        if (w_bit) begin
          w_next     = ADDR;
          w_next_cnt = '0;
        end
      end
      ADDR: begin
        if (!SEL) begin
          w_next     = IDLE;
          w_next_cnt = '0;
        end else if (BUS_VALID) begin
          if (r_cnt == ADDR_LAST) begin
            w_next     = r_rw ? WDATA : MEM_RD;
            w_next_cnt = '0;
          end else begin
            w_next_cnt = r_cnt + CNT_ONE;
          end
        end
      end
      WDATA: begin
        if (!SEL) begin
          w_next     = IDLE;
          w_next_cnt = '0;
        end else if (BUS_VALID) begin
          if (r_cnt == BYTE_LAST) begin
            w_next     = MEM_WR;
            w_next_cnt = '0;
          end else begin
            w_next_cnt = r_cnt + CNT_ONE;
          end
        end
      end
      MEM_WR: begin
        w_next     = IDLE;
        w_next_cnt = '0;
      end
      MEM_RD: begin
        // r_ren marks the strobe cycle, in which the memory cannot answer yet.
        if (S_DVALID && !r_ren) begin
          w_next       = TX;
          w_next_cnt   = '0;
          w_next_shift = S_DIN;
        end
`ifdef SPLIT_EN
        else if (r_cnt == SPLIT_LAST) begin
          w_next     = SPLIT;
          w_next_cnt = '0;
          w_next_got = 1'b0;
        end else begin
          w_next_cnt = r_cnt + CNT_ONE;
        end
`endif
      end
`ifdef SPLIT_EN
      SPLIT: begin
        if (S_DVALID && !r_got) begin
          w_next_shift = S_DIN;
          w_next_got   = 1'b1;
        end
        if (SEL && (r_got || S_DVALID)) begin
          w_next     = TX;
          w_next_cnt = '0;
          w_next_got = 1'b0;
        end
      end
`endif
      TX: begin
        if (!SEL || (r_cnt == BYTE_LAST)) begin
          w_next     = IDLE;
          w_next_cnt = '0;
        end else begin
          w_next_cnt   = r_cnt + CNT_ONE;
          w_next_shift = {r_shift[6:0], 1'b0};
        end
      end
      default: begin
        w_next     = IDLE;
        w_next_cnt = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_dout      <= '0;
      r_wen       <= 1'b0;
      r_ren       <= 1'b0;
      r_ack       <= 1'b0;
      r_slv_valid <= 1'b0;
      r_slv_data  <= 1'b0;
`ifdef SPLIT_EN
      r_got       <= 1'b0;
      r_split     <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so all update together.
      r_state <= w_next;
      r_cnt   <= w_next_cnt;
      r_shift <= w_next_shift;
      if ((r_state == IDLE) && w_bit) r_rw <= BUS_DATA;
      if ((r_state == ADDR) && w_bit) r_addr <= {r_addr[ADDR_W-2:0], BUS_DATA};
      if ((r_state == WDATA) && w_bit) r_dout <= {r_dout[6:0], BUS_DATA};
      // Strobes and serial outputs are decoded from the next state so they are
      // registered yet line up with the state they belong to.
      r_wen       <= (w_next == MEM_WR);
      r_ren       <= (w_next == MEM_RD) && (r_state != MEM_RD);
      r_ack       <= (r_state == MEM_WR);
      r_slv_valid <= (w_next == TX);
      r_slv_data  <= (w_next == TX) && w_next_shift[7];
`ifdef SPLIT_EN
      r_got       <= w_next_got;
      r_split     <= (w_next == SPLIT);
`endif
    end
  end

  assign SLV_VALID = r_slv_valid;
  assign SLV_DATA  = r_slv_data;
  assign SLV_ACK   = r_ack;
  assign S_ADDR    = r_addr;
  assign S_DOUT    = r_dout;
  assign S_WEN     = r_wen;
  assign S_REN     = r_ren;
`ifdef SPLIT_EN
  assign SLV_SPLIT = r_split;
`else
  assign SLV_SPLIT = 1'b0;
`endif

endmodule

// File: tb/tb_bus_slave_port.sv
// Self-checking bench for bus_slave_port: the bench plays bus master and local
// memory, and predicts every strobe and serial bit from the frame rules.
`timescale 1ns/1ps

module tb_bus_slave_port;

  localparam int ADDR_W = 12;
  localparam int THRESH = 4;
`ifdef SPLIT_EN
  localparam bit SPLIT_ON = 1'b1;
`else
  localparam bit SPLIT_ON = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RSTN = 1'b1;
  logic              SEL = 1'b0;
  logic              BUS_VALID = 1'b0;
  logic              BUS_DATA = 1'b0;
  logic [7:0]        S_DIN = '0;
  logic              S_DVALID = 1'b0;
  logic              SLV_VALID;
  logic              SLV_DATA;
  logic              SLV_ACK;
  logic              SLV_SPLIT;
  logic [ADDR_W-1:0] S_ADDR;
  logic [7:0]        S_DOUT;
  logic              S_WEN;
  logic              S_REN;

  int n_checks = 0;
  int n_fail   = 0;
  int wen_cnt  = 0;
  int ren_cnt  = 0;
  logic [7:0] mem [0:4095];

  always #5 CLK = ~CLK;

  bus_slave_port #(.ADDR_W(ADDR_W), .SPLIT_THRESH(THRESH)) dut (
    .CLK(CLK), .RSTN(RSTN), .SEL(SEL), .BUS_VALID(BUS_VALID), .BUS_DATA(BUS_DATA),
    .SLV_VALID(SLV_VALID), .SLV_DATA(SLV_DATA), .SLV_ACK(SLV_ACK), .SLV_SPLIT(SLV_SPLIT),
    .S_ADDR(S_ADDR), .S_DOUT(S_DOUT), .S_WEN(S_WEN), .S_REN(S_REN),
    .S_DIN(S_DIN), .S_DVALID(S_DVALID)
  );

  // Strobe pulse counters, sampled mid-cycle.
  always @(negedge CLK) begin
    if (S_WEN === 1'b1) wen_cnt <= wen_cnt + 1;
    if (S_REN === 1'b1) ren_cnt <= ren_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_bits(input logic [20:0] bits, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      int g;
      g = (i == n - 1) ? 0 : ((gap < 0) ? int'($urandom_range(0, 2)) : gap);
      repeat (g) begin
        BUS_VALID = 1'b0;
        BUS_DATA  = 1'($urandom);
        S_DVALID  = 1'($urandom);
        S_DIN     = 8'($urandom);
        cyc();
      end
      BUS_VALID = 1'b1;
      BUS_DATA  = bits[i];
      S_DVALID  = 1'($urandom);
      S_DIN     = 8'($urandom);
      cyc();
    end
    BUS_VALID = 1'b0;
    S_DVALID  = 1'b0;
  endtask

  task automatic send_frame(input logic rw, input logic [11:0] addr, input logic [7:0] data,
                            input int gap);
    if (rw) send_bits({1'b1, addr, data}, 21, gap);
    else    send_bits({8'h00, 1'b0, addr}, 13, gap);
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [7:0] data, input int gap);
    int w0;
    w0 = wen_cnt;
    send_frame(1'b1, addr, data, gap);
    n_checks++;
    if ({S_WEN, SLV_ACK, S_ADDR, S_DOUT} !== {1'b1, 1'b0, addr, data}) begin
      n_fail++;
      $display("FAIL write_strobe: wen=%b ack=%b addr=%h dout=%h, expected wen=1 ack=0 addr=%h dout=%h",
               S_WEN, SLV_ACK, S_ADDR, S_DOUT, addr, data);
    end
    cyc();
    n_checks++;
    if (S_WEN !== 1'b0 || SLV_ACK !== 1'b1 || (wen_cnt - w0) != 1) begin
      n_fail++;
      $display("FAIL write_ack: wen=%b ack=%b wen_pulses=%0d, expected wen=0 ack=1 wen_pulses=1",
               S_WEN, SLV_ACK, wen_cnt - w0);
    end
    mem[addr] = data;
  endtask

  // cut_mode: 0 none, 1 drop SEL after TX bit cut_at, 2 reset after TX bit cut_at.
  task automatic do_read(input logic [11:0] addr, input int gap, input int lat,
                         input logic [7:0] rbyte, input bit sel_low,
                         input int cut_mode, input int cut_at);
    int  r0;
    logic exp_split;
    r0 = ren_cnt;
    send_frame(1'b0, addr, 8'h00, gap);
    S_DVALID = 1'b0;
    n_checks++;
    if (S_ADDR !== addr) begin
      n_fail++;
      $display("FAIL read_addr: addr=%h expected %h", S_ADDR, addr);
    end
    for (int k = 0; k < lat; k++) begin
      exp_split = SPLIT_ON && (k >= THRESH);
      n_checks++;
      if ({S_REN, SLV_VALID, SLV_SPLIT} !== {(k == 0), 1'b0, exp_split}) begin
        n_fail++;
        $display("FAIL read_wait[%0d]: ren=%b valid=%b split=%b, expected ren=%b valid=0 split=%b",
                 k, S_REN, SLV_VALID, SLV_SPLIT, (k == 0), exp_split);
      end
      if (sel_low && k == 1) SEL = 1'b0;
      cyc();
    end
    S_DVALID  = 1'b1;
    S_DIN     = rbyte;
    exp_split = SPLIT_ON && (lat >= THRESH);
    n_checks++;
    if ({SLV_VALID, SLV_SPLIT} !== {1'b0, exp_split}) begin
      n_fail++;
      $display("FAIL read_dvalid_cycle: valid=%b split=%b, expected valid=0 split=%b",
               SLV_VALID, SLV_SPLIT, exp_split);
    end
    cyc();
    S_DVALID = 1'b0;
    S_DIN    = 8'($urandom);
    if (sel_low) begin
      for (int h = 0; h < 4; h++) begin
        if (h == 3) SEL = 1'b1;
        n_checks++;
        if ({SLV_SPLIT, SLV_VALID} !== 2'b10) begin
          n_fail++;
          $display("FAIL split_hold[%0d]: split=%b valid=%b, expected split=1 valid=0",
                   h, SLV_SPLIT, SLV_VALID);
        end
        cyc();
      end
    end
    for (int i = 7; i >= 0; i--) begin
      n_checks++;
      if ({SLV_VALID, SLV_DATA, SLV_SPLIT, S_REN} !== {1'b1, rbyte[i], 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL tx_bit[%0d]: valid=%b data=%b split=%b ren=%b, expected valid=1 data=%b split=0 ren=0",
                 i, SLV_VALID, SLV_DATA, SLV_SPLIT, S_REN, rbyte[i]);
      end
      if (cut_mode == 1 && i == cut_at) begin
        SEL = 1'b0;
        cyc();
        for (int j = 0; j < 3; j++) begin
          n_checks++;
          if ({SLV_VALID, SLV_DATA} !== 2'b00) begin
            n_fail++;
            $display("FAIL tx_abort[%0d]: valid=%b data=%b, expected 0 0", j, SLV_VALID, SLV_DATA);
          end
          cyc();
        end
        SEL = 1'b1;
        return;
      end
      if (cut_mode == 2 && i == cut_at) begin
        #1 RSTN = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) begin
          n_checks++;
          if ({SLV_VALID, SLV_DATA, SLV_ACK, SLV_SPLIT, S_WEN, S_REN, S_ADDR, S_DOUT} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_mid_tx[%0d]: valid=%b data=%b ack=%b split=%b wen=%b ren=%b addr=%h dout=%h, expected all 0",
                     j, SLV_VALID, SLV_DATA, SLV_ACK, SLV_SPLIT, S_WEN, S_REN, S_ADDR, S_DOUT);
          end
          if (j < 2) cyc();
        end
        #1 RSTN = 1'b1;
        cyc();
        return;
      end
      cyc();
    end
    n_checks++;
    if (SLV_VALID !== 1'b0 || (ren_cnt - r0) != 1) begin
      n_fail++;
      $display("FAIL read_end: valid=%b ren_pulses=%0d, expected valid=0 ren_pulses=1",
               SLV_VALID, ren_cnt - r0);
    end
  endtask

  // Quiet cycles with stray S_DVALID noise; only a pending ACK may show.
  task automatic idle(input int n, input bit prev_write);
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if ({SLV_VALID, S_WEN, S_REN, SLV_SPLIT, SLV_ACK} !== {4'b0000, prev_write && (i == 0)}) begin
        n_fail++;
        $display("FAIL idle[%0d]: valid=%b wen=%b ren=%b split=%b ack=%b, expected 0 0 0 0 %b",
                 i, SLV_VALID, S_WEN, S_REN, SLV_SPLIT, SLV_ACK, prev_write && (i == 0));
      end
      BUS_VALID = 1'b0;
      S_DVALID  = 1'($urandom);
      S_DIN     = 8'($urandom);
      cyc();
    end
    S_DVALID = 1'b0;
  endtask

  task automatic test_reset();
    #2 RSTN = 1'b0;
    SEL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      BUS_VALID = 1'b1;
      BUS_DATA  = 1'($urandom);
      S_DVALID  = 1'($urandom);
      cyc();
      n_checks++;
      if ({SLV_VALID, SLV_DATA, SLV_ACK, SLV_SPLIT, S_WEN, S_REN, S_ADDR, S_DOUT} !== 26'd0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: valid=%b data=%b ack=%b split=%b wen=%b ren=%b addr=%h dout=%h, expected all 0",
                 i, SLV_VALID, SLV_DATA, SLV_ACK, SLV_SPLIT, S_WEN, S_REN, S_ADDR, S_DOUT);
      end
    end
    BUS_VALID = 1'b0;
    S_DVALID  = 1'b0;
    #2 RSTN = 1'b1;
    cyc();
  endtask

  task automatic test_write();
    do_write(12'h5A3, 8'hAD, 0);
    idle(2, 1'b1);
    do_write(12'h5A3, 8'hAD, 3);
    idle(2, 1'b1);
  endtask

  task automatic test_read();
    do_read(12'h2C7, 0, 2, 8'hC3, 1'b0, 0, 0);
    idle(2, 1'b0);
    do_read(12'h111, 1, 10, 8'h96, 1'b0, 0, 0);
    idle(1, 1'b0);
  endtask

  task automatic test_abort_addr();
    logic [20:0] v;
    int w0, r0;
    v = '0;
    v[6:0] = 7'b1101101;
    w0 = wen_cnt;
    r0 = ren_cnt;
    send_bits(v, 7, 0);
    SEL = 1'b0;
    for (int i = 0; i < 4; i++) begin
      BUS_VALID = 1'($urandom);
      BUS_DATA  = 1'($urandom);
      cyc();
    end
    BUS_VALID = 1'b0;
    SEL = 1'b1;
    n_checks++;
    if ((wen_cnt - w0) != 0 || (ren_cnt - r0) != 0 || S_WEN !== 1'b0 || S_REN !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_addr: wen_pulses=%0d ren_pulses=%0d, expected 0 0", wen_cnt - w0, ren_cnt - r0);
    end
    do_write(12'hABC, 8'h5E, 0);
    idle(1, 1'b1);
  endtask

  task automatic test_abort_tx();
    do_read(12'h3D1, 0, 3, 8'hF0, 1'b0, 1, 4);
    do_read(12'h3D2, 0, 1, 8'h0F, 1'b0, 0, 0);
    idle(1, 1'b0);
  endtask

  task automatic test_split();
`ifdef SPLIT_EN
    do_read(12'h0F0, 0, 10, 8'h3C, 1'b1, 0, 0);
    idle(1, 1'b0);
    do_read(12'h0F1, 0, THRESH - 1, 8'h81, 1'b0, 0, 0);
    idle(1, 1'b0);
    do_read(12'h0F2, 0, THRESH, 8'h7E, 1'b0, 0, 0);
    idle(1, 1'b0);
`endif
  endtask

  task automatic test_reset_mid_tx();
    do_read(12'h6B9, 0, 2, 8'hA5, 1'b0, 2, 5);
    do_write(12'h123, 8'h45, 0);
    idle(1, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_write(12'h010, 8'h11, 0);
    do_read(12'h010, 0, 1, mem[12'h010], 1'b0, 0, 0);
    do_write(12'h020, 8'h22, 0);
    idle(1, 1'b1);
  endtask

  task automatic test_random();
    logic [11:0] a;
    logic [7:0]  d;
    bit          rw;
    for (int t = 0; t < 40; t++) begin
      rw = 1'($urandom);
      a  = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 15)) : 12'($urandom);
      if (rw) begin
        d = 8'($urandom);
        do_write(a, d, -1);
        idle($urandom_range(1, 3), 1'b1);
      end else begin
        do_read(a, -1, $urandom_range(1, 12), mem[a], 1'b0, 0, 0);
        idle($urandom_range(0, 3), 1'b0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    test_reset();
    test_write();
    test_read();
    test_abort_addr();
    test_abort_tx();
    test_split();
    test_reset_mid_tx();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_slave_port.md
BUS_SLAVE_PORT -- requirements
Module: bus_slave_port

Interface
REQ-001 SHALL provide parameter ADDR_W, default 12, local address width.
REQ-002 SHALL provide parameter SPLIT_THRESH, default 4, cycles waited for read data before split.
REQ-003 CLK  input  1  single clock; all logic on rising edge.
REQ-004 RSTN  input  1  reset, asynchronous, active-low.
REQ-005 SEL  input  1  slave selected by bus decoder/arbiter.
REQ-006 BUS_VALID  input  1  master serial bit valid this cycle.
REQ-007 BUS_DATA  input  1  master serial bit, MSB first.
REQ-008 SLV_VALID  output  1  slave read-data bit valid.
REQ-009 SLV_DATA  output  1  slave serial read-data bit, MSB first.
REQ-010 SLV_ACK  output  1  one-cycle write-complete pulse.
REQ-011 SLV_SPLIT  output  1  split request to arbiter.
REQ-012 S_ADDR  output  ADDR_W  local address.
REQ-013 S_DOUT  output  8  local write data.
REQ-014 S_WEN  output  1  local write strobe, one cycle.
REQ-015 S_REN  output  1  local read strobe, one cycle.
REQ-016 S_DIN  input  8  local read data.
REQ-017 S_DVALID  input  1  S_DIN valid, any latency >=1 cycle after S_REN.

Function
REQ-018 Frame SHALL be: RW bit (1=write), ADDR_W address bits, then 8 data bits for writes only; a bit counts only in cycles with SEL=1 and BUS_VALID=1.
REQ-019 States SHALL be IDLE, ADDR, WDATA, MEM_WR, MEM_RD, SPLIT, TX.
REQ-020 IDLE->ADDR on first counted bit, capturing RW; ADDR->WDATA (write) or MEM_RD (read) after ADDR_W-th address bit; WDATA->MEM_WR after 8th data bit.
REQ-021 BUS_VALID=0 with SEL=1 in ADDR/WDATA SHALL stall the bit counter without aborting.
REQ-022 MEM_WR SHALL drive S_WEN=1 for exactly one cycle with S_ADDR/S_DOUT stable, assert SLV_ACK in the following cycle, then return to IDLE.
REQ-023 MEM_RD SHALL drive S_REN=1 in its first cycle only, then wait; on S_DVALID=1 it SHALL latch S_DIN and enter TX.
REQ-024 TX SHALL drive SLV_VALID=1 for 8 consecutive cycles with SLV_DATA = latched byte MSB first, then return to IDLE.
REQ-025 SEL falling in ADDR, WDATA or TX SHALL abort to IDLE with no S_WEN, S_REN or further SLV_VALID.
REQ-026 S_DVALID when not in MEM_RD/SPLIT SHALL be ignored.
REQ-027 Outputs SLV_VALID, SLV_DATA, SLV_ACK, SLV_SPLIT, S_WEN, S_REN SHALL be registered.

Reset
REQ-028 RSTN=0 SHALL force state IDLE, counters 0, and all outputs 0 (including S_ADDR, S_DOUT) asynchronously, including mid-frame or mid-split.
REQ-029 First frame bit SHALL be accepted no earlier than the first rising edge after RSTN rises.

Configuration
REQ-030 Macro SPLIT_EN SHALL, when defined, enable split: if S_DVALID absent for SPLIT_THRESH cycles in MEM_RD, enter SPLIT and assert SLV_SPLIT.
REQ-031 In SPLIT, SEL=0 SHALL NOT abort; on S_DVALID the data SHALL be latched and SLV_SPLIT held until SEL=1, then SLV_SPLIT drops and TX begins next cycle.
REQ-032 S_DVALID in the same cycle as threshold expiry SHALL take priority: no split, enter TX.
REQ-033 Without SPLIT_EN, SLV_SPLIT SHALL be constant 0, SPLIT state absent, and MEM_RD waits indefinitely.

Verification
REQ-034 Write: RW=1, addr 0x5A3, data 0xAD -> one S_WEN with S_ADDR=0x5A3, S_DOUT=0xAD, SLV_ACK one cycle later.
REQ-035 Read, S_DVALID 2 cycles after S_REN, S_DIN=0xC3 -> SLV_VALID 8 cycles, SLV_DATA 1,1,0,0,0,0,1,1, no SLV_SPLIT.
REQ-036 Write with BUS_VALID gaps of 3 cycles between bits -> same result as REQ-034.
REQ-037 SEL dropped after 6 address bits -> IDLE, no S_WEN/S_REN; next full frame completes normally.
REQ-038 SPLIT_EN, read latency 10 cycles, SEL low during wait, S_DIN=0x3C -> SLV_SPLIT after 4 cycles, held until SEL re-asserted, then 0x3C shifted out.
REQ-039 RSTN pulsed low mid-TX -> all outputs 0 immediately, IDLE after release.
